// File: rtl/audio_ram_rw.sv
// Record/playback sequencer between a stereo codec stream and a shared sample RAM.
// Two regions (Rx capture, processed) each remember how many words were last recorded.
module audio_ram_rw #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              daclrck,
   input  logic              req_valid,
   input  logic              req_type,
   input  logic              req_target,
   output logic              req_ready,
   input  logic              stop,
   output logic              busy,
   input  logic              rx_valid,
   input  logic [15:0]       rx_l_data,
   input  logic [15:0]       rx_r_data,
   input  logic              sample_tick,
   output logic              data_valid,
   output logic [15:0]       data_out_l,
   output logic [15:0]       data_out_r,
   output logic [ADDR_W:0]   mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata
);

   localparam int            CW    = ADDR_W + 1;
   localparam logic [ADDR_W:0] ONE   = CW'(1);
   localparam logic [ADDR_W:0] DEPTH = ONE << ADDR_W;
   localparam logic [ADDR_W:0] LAST  = DEPTH - ONE;

   typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;

   state_t                   state, state_nxt;
   logic                     tgt;
   logic [ADDR_W:0]          wr_ptr, rd_ptr;
   logic [1:0][ADDR_W:0]     len;
   logic [ADDR_W:0]          cur_len;

   logic                     accept, wr_inc, rd_inc, len_we, cap_rd;
   logic [ADDR_W:0]          len_val;

   assign cur_len   = len[tgt];
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      wr_inc    = 1'b0;
      rd_inc    = 1'b0;
      len_we    = 1'b0;
      len_val   = wr_ptr;
      cap_rd    = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = req_type ? WRITE : READ;
            end
         end
         WRITE: begin
            // stop wins over a coincident sample so the recorded length is exact
            if (stop) begin
               state_nxt = IDLE;
               len_we    = 1'b1;
               len_val   = wr_ptr;
            end else if (rx_valid) begin
               mem_we    = 1'b1;
               mem_addr  = {tgt, wr_ptr[ADDR_W-1:0]};
               mem_wdata = {rx_l_data, rx_r_data};
               wr_inc    = 1'b1;
               if (wr_ptr == LAST) begin
                  state_nxt = IDLE;
                  len_we    = 1'b1;
                  len_val   = DEPTH;
               end
            end
         end
         READ: begin
            if (stop || cur_len == '0) begin
               state_nxt = IDLE;
            end else if (sample_tick) begin
               mem_re    = 1'b1;
               mem_addr  = {tgt, rd_ptr[ADDR_W-1:0]};
               rd_inc    = 1'b1;
               state_nxt = READ_WAIT;
            end
         end
         READ_WAIT: begin
            // the word in flight is always delivered, even when stopping
            cap_rd    = 1'b1;
            state_nxt = (stop || rd_ptr == cur_len) ? IDLE : READ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge daclrck) begin
      if (daclrck) begin
         state      <= IDLE;
         tgt        <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         len        <= '0;
         data_valid <= 1'b0;
         data_out_l <= '0;
         data_out_r <= '0;
      end else begin
         state      <= state_nxt;
         data_valid <= cap_rd;
         if (accept) begin
            tgt    <= req_target;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end
         if (wr_inc) wr_ptr <= wr_ptr + ONE;
         if (rd_inc) rd_ptr <= rd_ptr + ONE;
         if (len_we) len[tgt] <= len_val;
         if (cap_rd) begin
            data_out_l <= mem_rdata[31:16];
            data_out_r <= mem_rdata[15:0];
         end
      end
   end

endmodule

// File: doc/audio_ram_rw.md
AUDIO_RAM_RW -- requirements
Module: audio_ram_rw

Interface
REQ-001 Parameter ADDR_W, default 16: sample-address width per region, DEPTH = 2**ADDR_W stereo words per region.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 daclrck  in  1  reset, asynchronous, active-high; clock clk.
REQ-004 req_valid  in  1  request strobe from the record/play controller.
REQ-005 req_type  in  1  1 = write (record), 0 = read (play); sampled with req_valid.
REQ-006 req_target  in  1  region select (0 = Rx region, 1 = processed region); sampled with req_valid.
REQ-007 req_ready  out  1  high exactly when the FSM is in IDLE.
REQ-008 stop  in  1  level; 1 terminates the active transfer.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 rx_valid  in  1  one-cycle strobe: new capture sample on rx_l_data/rx_r_data.
REQ-011 rx_l_data, rx_r_data  in  16 each  capture sample.
REQ-012 sample_tick  in  1  one-cycle playback pacing strobe, one per sample period.
REQ-013 data_valid  out  1  one-cycle strobe: new playback sample on data_out_l/data_out_r.
REQ-014 data_out_l, data_out_r  out  16 each  playback sample, held until next data_valid.
REQ-015 mem_addr  out  ADDR_W+1  {region, sample index}.
REQ-016 mem_wdata  out  32  {left, right}; mem_we  out  1  one-cycle write strobe.
REQ-017 mem_re  out  1  one-cycle read strobe; mem_rdata  in  32  valid exactly 1 cycle after mem_re.

Function
REQ-018 States IDLE, WRITE, READ, READ_WAIT; any unused encoding returns to IDLE.
REQ-019 IDLE: req_valid=1 accepted same cycle (req_ready=1); type and target latched; write -> WRITE with wr_ptr=0; read -> READ with rd_ptr=0.
REQ-020 req_valid while busy is ignored: no latch, no state change.
REQ-021 WRITE: rx_valid=1 and stop=0 -> mem_we=1, mem_addr={target, wr_ptr}, mem_wdata={rx_l_data, rx_r_data} that cycle, wr_ptr increments.
REQ-022 WRITE: stop=1 -> IDLE next cycle; len[target] <= wr_ptr; rx_valid in the same cycle is dropped (stop wins).
REQ-023 WRITE: write at wr_ptr = DEPTH-1 -> IDLE next cycle, len[target] <= DEPTH; no wrap, no overwrite of index 0.
REQ-024 Two length registers len[0], len[1], ADDR_W+1 bits wide, reset to 0; updated only on WRITE exit.
REQ-025 READ entry with len[target]=0 -> IDLE next cycle, no mem_re, no data_valid.
REQ-026 READ: sample_tick=1 and stop=0 -> mem_re=1, mem_addr={target, rd_ptr}, rd_ptr increments, -> READ_WAIT.
REQ-027 READ_WAIT (1 cycle): data_out_l <= mem_rdata[31:16], data_out_r <= mem_rdata[15:0], data_valid=1; then IDLE if rd_ptr = len[target], else READ.
REQ-028 Latency sample_tick -> data_valid: exactly 2 clk rising edges.
REQ-029 READ: stop=1 -> IDLE next cycle; simultaneous sample_tick ignored; stop in READ_WAIT does not suppress that sample, FSM then goes to IDLE.
REQ-030 sample_tick outside READ, rx_valid outside WRITE: ignored.
REQ-031 mem_we and mem_re never both high; neither high in IDLE.

Reset
REQ-032 daclrck=1 asynchronously forces: state IDLE, wr_ptr=rd_ptr=0, len[0]=len[1]=0, data_out_l=data_out_r=0, data_valid=0, mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
REQ-033 After reset: busy=0, req_ready=1.
REQ-034 Reset mid-transfer: the transfer is abandoned; the transfer's length register is not updated (it is cleared by REQ-032).

Verification
REQ-035 Bench ADDR_W=4. Write to target 0, 3 rx_valid samples (0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666), stop -> mem writes at addresses 0,1,2; len[0]=3; busy falls.
REQ-036 Read target 0, 4 sample_ticks -> data_valid 2 cycles after each of the first 3 ticks, values as written; IDLE after 3rd; 4th tick ignored.
REQ-037 Write target 1, 20 rx_valid, stop never asserted -> 16 writes (addresses 16..31), auto-IDLE, len[1]=16.
REQ-038 Read target 1 with len[1]=0 (fresh reset) -> busy for 1 cycle, no mem_re, no data_valid.
REQ-039 stop and rx_valid in the same cycle during WRITE -> no mem_we; length equals the count of prior writes.
REQ-040 daclrck pulsed mid-READ -> all outputs at reset values immediately; req_ready=1 on the next edge.
